// File: rtl/mod_n_cascade_counter_pkg.sv
// Shared defaults and direction encoding for the cascaded mod-N counter.
package mod_n_cascade_counter_pkg;

    localparam int unsigned DEF_MOD    = 12;
    localparam int unsigned DEF_DIGITS = 2;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/mod_n_digit.sv
// One modulo-MOD digit: load (with out-of-range clamp to 0), or step up/down when enabled.
module mod_n_digit
    import mod_n_cascade_counter_pkg::*;
#(
    parameter int unsigned MOD = DEF_MOD,
    localparam int unsigned W  = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         up_dn,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         at_term
);

    localparam logic [W-1:0] MAXV = W'(MOD - 1);

    logic [W-1:0] r_q;
    logic         w_d_bad;

    // Widened compare so MOD=256 (not representable in W bits) still works.
    assign w_d_bad = ({1'b0, d} >= (W+1)'(MOD));
    assign at_term = (up_dn == UP) ? (r_q == MAXV) : (r_q == '0);
    assign q       = r_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= w_d_bad ? '0 : d;
        end else if (step) begin
            if (up_dn == UP) begin
                r_q <= (r_q == MAXV) ? '0 : r_q + W'(1);
            end else begin
                r_q <= (r_q == '0) ? MAXV : r_q - W'(1);
            end
        end
    end

endmodule

// File: rtl/mod_n_cascade_counter.sv
// Cascaded DIGITS x mod-MOD up/down counter with load, terminal count, wrap and load-error pulses.
module mod_n_cascade_counter
    import mod_n_cascade_counter_pkg::*;
#(
    parameter int unsigned MOD    = DEF_MOD,
    parameter int unsigned DIGITS = DEF_DIGITS,
    localparam int unsigned W     = $clog2(MOD)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up_dn,
    input  logic                load,
    input  logic [DIGITS*W-1:0] data_in,
    output logic [DIGITS*W-1:0] count,
    output logic                tc,
    output logic                wrap,
    output logic                load_err
);

    logic [DIGITS:0]   w_chain;
    logic [DIGITS-1:0] w_term;
    logic [DIGITS-1:0] w_bad;
    logic              r_wrap;
    logic              r_load_err;

    // w_chain[i] enables digit i: en AND every lower digit at its terminal value.
    assign w_chain[0] = en;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            mod_n_digit #(.MOD(MOD)) u_digit (
                .clk     (clk),
                .rst     (rst),
                .step    (w_chain[g]),
                .up_dn   (up_dn),
                .load    (load),
                .d       (data_in[g*W +: W]),
                .q       (count[g*W +: W]),
                .at_term (w_term[g])
            );
            assign w_chain[g+1] = w_chain[g] & w_term[g];
            assign w_bad[g]     = ({1'b0, data_in[g*W +: W]} >= (W+1)'(MOD));
        end
    endgenerate

    assign tc       = w_chain[DIGITS] & ~load & rst;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= tc;
            r_load_err <= load & (|w_bad);
        end
    end

endmodule

// File: doc/mod_n_cascade_counter.md
MOD_N_CASCADE_COUNTER -- requirements
Module: mod_n_cascade_counter

Interface
REQ-001 The block SHALL have parameter MOD, default 12: modulus of each digit; legal range 2..256.
REQ-002 The block SHALL have parameter DIGITS, default 2: number of cascaded digits; legal range 1..8.
REQ-003 The block SHALL derive localparam W = $clog2(MOD), the digit width; total count width is DIGITS*W.
REQ-004 The block SHALL have port clk  input  1: the only clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1: reset, synchronous and active-low.
REQ-006 The block SHALL have port en  input  1: count enable; one step per enabled cycle.
REQ-007 The block SHALL have port up_dn  input  1: direction; 1 = up, 0 = down.
REQ-008 The block SHALL have port load  input  1: parallel load strobe.
REQ-009 The block SHALL have port data_in  input  DIGITS*W: load value; digit 0 in bits [W-1:0].
REQ-010 The block SHALL have port count  output  DIGITS*W: registered digit values, same packing as data_in.
REQ-011 The block SHALL have port tc  output  1: combinational terminal count; next enabled step wraps the whole counter.
REQ-012 The block SHALL have port wrap  output  1: registered pulse, high for one cycle after a full-counter wrap.
REQ-013 The block SHALL have port load_err  output  1: registered pulse, high for one cycle after a load containing any digit >= MOD.

Function
REQ-014 Priority at each rising edge SHALL be: reset, then load, then en; with none of these active, count SHALL hold.
REQ-015 On load, each digit SHALL take its data_in field one cycle later, regardless of en; no count step SHALL occur that cycle.
REQ-016 On load, any data_in digit >= MOD SHALL be loaded as 0, other digits as given, and load_err SHALL pulse on the next cycle.
REQ-017 Counting up with en=1: digit 0 SHALL increment; at MOD-1 it SHALL go to 0 and carry into digit 1; each higher digit SHALL step only when every lower digit is at MOD-1.
REQ-018 Counting down with en=1: digit 0 SHALL decrement; at 0 it SHALL go to MOD-1 and borrow from digit 1; each higher digit SHALL step only when every lower digit is at 0.
REQ-019 tc SHALL be 1 exactly when en=1, load=0, rst=1, and every digit is MOD-1 (up) or 0 (down).
REQ-020 wrap SHALL be 1 in the cycle following an edge at which tc was 1, and 0 otherwise.
REQ-021 No digit SHALL ever hold a value >= MOD.
REQ-022 A change of up_dn SHALL take effect at the next enabled edge, with no extra latency and no lost step.
REQ-023 Carry and borrow SHALL be computed combinationally across all digits, so the counter moves one full count per enabled cycle.

Reset
REQ-024 With rst=0 at a rising edge, count SHALL be 0 on every digit, and wrap and load_err SHALL be 0, overriding load and en.
REQ-025 Reset asserted mid-count or mid-load SHALL discard the operation; counting SHALL resume from 0 at the first enabled edge after rst returns to 1.
REQ-026 No output SHALL be X after the first reset edge; there SHALL be no asynchronous reset path.

Structure
REQ-027 A shared package SHALL hold the default MOD and DIGITS values and the direction encodings UP=1 and DOWN=0.
REQ-028 A sub-module mod_n_digit SHALL implement one digit, with ports: clk, rst, step, up_dn, load, d, q, at_term.
REQ-029 The top level SHALL instantiate DIGITS copies of mod_n_digit with a generate loop and chain their at_term signals into step enables.

Verification
REQ-030 Reset: MOD=12, DIGITS=2, rst=0 with load=1 and data_in={3,8} -> count={0,0}, wrap=0, load_err=0.
REQ-031 Count up: from {0,0} with en=1 and up_dn=1 -> after 12 edges count={1,0}; after 143 edges count={11,11} and tc=1; the next edge gives {0,0} and wrap=1 for one cycle.
REQ-032 Load with enable: load=1, en=1, data_in={3,8} -> count={3,8} with no step; the next enabled edge gives {3,9}.
REQ-033 Illegal load: data_in={13,5} -> count={0,5}, and load_err=1 for exactly one cycle.
REQ-034 Count down: from {0,0} with up_dn=0 and en=1 -> tc=1 and the next edge gives {11,11} with wrap=1; then toggling up_dn=1 gives {0,0}.
REQ-035 Mid-count reset: counting from {5,7} with rst=0 for one edge -> count={0,0}; after rst=1, the first enabled up edge gives {0,1}.
